// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider writing HI/LO.
// Division is built only when MULT_DIV_DIVIDE_EN is defined; otherwise div_op is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic             div_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic               sign_a, sign_b;
  logic               accept, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step, mul_res, step_val;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept    = start_mult && (state == S_IDLE || state == S_DONE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign a_mag     = (mult_sign && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag     = (mult_sign && src_b[WIDTH-1]) ? -src_b : src_b;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_mult) state_nxt = S_RUN;
      S_RUN:   if (last_iter)  state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = start_mult ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_FIX);
    done = (state == S_DONE);
  end

  // prod = {partial product, remaining multiplier bits}; one bit retired per cycle
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, prod[WIDTH-1:1]};
  assign mul_res  = (sign_a ^ sign_b) ? -prod : prod;

`ifdef MULT_DIV_DIVIDE_EN
  logic             is_div;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub, quo, rem;

  // prod = {partial remainder, dividend bits not yet shifted in / quotient bits}
  assign div_tmp = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign div_ge  = (div_tmp >= {1'b0, opnd});
  // when div_ge holds the true difference is below the divisor, so WIDTH bits suffice
  assign div_sub = div_tmp[WIDTH-1:0] - opnd;
  assign quo     = prod[WIDTH-1:0];
  assign rem     = prod[2*WIDTH-1:WIDTH];

  always_comb begin
    step_val = mul_step;
    res_hi   = mul_res[2*WIDTH-1:WIDTH];
    res_lo   = mul_res[WIDTH-1:0];
    if (is_div) begin
      step_val = div_ge ? {div_sub, prod[WIDTH-2:0], 1'b1}
                        : {div_tmp[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      if (opnd == '0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_lo = (sign_a ^ sign_b) ? -quo : quo;
        res_hi = sign_a ? -rem : rem;
      end
    end
  end
`else
  logic unused_div_op;
  assign unused_div_op = div_op;

  always_comb begin
    step_val = mul_step;
    res_hi   = mul_res[2*WIDTH-1:WIDTH];
    res_lo   = mul_res[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      opnd   <= '0;
      prod   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULT_DIV_DIVIDE_EN
      is_div <= 1'b0;
      a_raw  <= '0;
`endif
    end else begin
      if (accept) begin
        cnt    <= '0;
        sign_a <= mult_sign & src_a[WIDTH-1];
        sign_b <= mult_sign & src_b[WIDTH-1];
`ifdef MULT_DIV_DIVIDE_EN
        is_div <= div_op;
        a_raw  <= src_a;
        opnd   <= div_op ? b_mag : a_mag;
        prod   <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
`else
        opnd   <= a_mag;
        prod   <= {{WIDTH{1'b0}}, b_mag};
`endif
      end else if (state == S_RUN) begin
        prod <= step_val;
        cnt  <= cnt + 1'b1;
      end
      // results change only when an operation completes
      if (state == S_FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner sequences, random vs model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start_mult, mult_sign, div_op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
    .div_op(div_op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         sg, dv;
    logic [W-1:0] ehi, elo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sg, input logic dv);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    if (dv) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (sg) begin
        sa = $signed(a);
        sb = $signed(b);
        if (a == 32'h8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      return {a % b, a / b};
    end
    if (sg) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    u = {32'h0, a} * {32'h0, b};
    return u;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op from IDLE/DONE; returns result, edges from accept to done, busy-cycle count.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        input logic dv, output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                        output int lat, output int bcnt);
    start_mult = 1'b1; src_a = a; src_b = b; mult_sign = sg; div_op = dv;
    @(posedge clk); #1;
    start_mult = 1'b0;
    src_a = 32'($urandom); src_b = 32'($urandom);
    mult_sign = 1'($urandom_range(0, 1)); div_op = 1'($urandom_range(0, 1));
    lat = -1; bcnt = 0;
    for (int e = 0; e < 200; e++) begin
      if (busy) bcnt++;
      if (done) begin lat = e; break; end
      @(posedge clk); #1;
    end
    rhi = hi; rlo = lo;
  endtask

  initial begin
    logic [W-1:0] rh, rl, lo1, lo2;
    logic [63:0]  ex;
    int lat, bc, nd, first, d1, d2;
    logic sg, dv;

    tbl.push_back(vec_t'{32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'h2A});
    tbl.push_back(vec_t'{32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    tbl.push_back(vec_t'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h1});
    tbl.push_back(vec_t'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h1});
    tbl.push_back(vec_t'{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h4000_0000, 32'h0});
    tbl.push_back(vec_t'{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hC000_0000, 32'h8000_0000});
    tbl.push_back(vec_t'{32'h8000_0000, 32'd2, 1'b0, 1'b0, 32'h1, 32'h0});
    tbl.push_back(vec_t'{32'h0, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 32'h0});
`ifdef MULT_DIV_DIVIDE_EN
    tbl.push_back(vec_t'{32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14});
    tbl.push_back(vec_t'{32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tbl.push_back(vec_t'{32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h1, 32'hFFFF_FFFD});
    tbl.push_back(vec_t'{32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 32'hFFFF_FFFF});
    tbl.push_back(vec_t'{32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    tbl.push_back(vec_t'{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h8000_0000});
    tbl.push_back(vec_t'{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF});
`else
    // div_op without the divider: still a multiply
    tbl.push_back(vec_t'{32'd100, 32'd7, 1'b0, 1'b1, 32'h0, 32'h2BC});
`endif

    reset = 1'b1; start_mult = 1'b0; mult_sign = 1'b0; div_op = 1'b0;
    src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].dv, rh, rl, lat, bc);
      chk($sformatf("vec%0d hi", i), 64'(rh), 64'(tbl[i].ehi));
      chk($sformatf("vec%0d lo", i), 64'(rl), 64'(tbl[i].elo));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(W + 1));
      chk($sformatf("vec%0d busy cycles", i), 64'(bc), 64'(W + 1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d lo held", i), 64'(lo), 64'(tbl[i].elo));
    end

    // start while busy is ignored; inputs are held from the accepting edge
    start_mult = 1'b1; src_a = 32'd7; src_b = 32'd6; mult_sign = 1'b0; div_op = 1'b0;
    @(posedge clk); #1;
    start_mult = 1'b0; nd = 0; first = -1;
    for (int c = 0; c < 80; c++) begin
      if (done) begin nd++; if (first < 0) first = c; end
      if (c == 5) src_a = 32'h55;
      if (c == 10) begin start_mult = 1'b1; src_a = 32'd9; src_b = 32'd9; end
      if (c == 11) start_mult = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy-start done count", 64'(nd), 64'd1);
    chk("busy-start done cycle", 64'(first), 64'(W + 1));
    chk("busy-start lo", 64'(lo), 64'h2A);
    chk("busy-start hi", 64'(hi), 64'h0);

    // reset mid-run abandons the op and clears results
    start_mult = 1'b1; src_a = 32'd7; src_b = 32'd6; mult_sign = 1'b0; div_op = 1'b0;
    @(posedge clk); #1;
    start_mult = 1'b0; nd = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 13) begin
        chk("mid-reset busy", 64'(busy), 64'd0);
        chk("mid-reset hi", 64'(hi), 64'd0);
        chk("mid-reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
      end
      if (done) nd++;
      if (c == 12) reset = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid-reset no done", 64'(nd), 64'd0);
    run_op(32'd3, 32'd4, 1'b0, 1'b0, rh, rl, lat, bc);
    chk("post-reset lo", 64'(rl), 64'hC);
    chk("post-reset hi", 64'(rh), 64'h0);
    chk("post-reset latency", 64'(lat), 64'(W + 1));
    @(posedge clk); #1;

    // start held high: back-to-back issue from DONE
    start_mult = 1'b1; src_a = 32'd2; src_b = 32'd3; mult_sign = 1'b0; div_op = 1'b0;
    @(posedge clk); #1;
    src_a = 32'd4; src_b = 32'd5;
    d1 = -1; d2 = -1; lo1 = '0; lo2 = '0;
    for (int c = 0; c < 120; c++) begin
      if (done) begin
        if (d1 < 0) begin d1 = c; lo1 = lo; end
        else begin d2 = c; lo2 = lo; start_mult = 1'b0; break; end
      end
      @(posedge clk); #1;
    end
    start_mult = 1'b0;
    chk("b2b first done", 64'(d1), 64'(W + 1));
    chk("b2b spacing", 64'(d2 - d1), 64'(W + 2));
    chk("b2b lo1", 64'(lo1), 64'd6);
    chk("b2b lo2", 64'(lo2), 64'd20);
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      ra = rnd_opnd(); rb = rnd_opnd();
      sg = 1'($urandom_range(0, 1));
`ifdef MULT_DIV_DIVIDE_EN
      dv = 1'($urandom_range(0, 1));
`else
      dv = 1'b0;
`endif
      run_op(ra, rb, sg, dv, rh, rl, lat, bc);
      ex = model(ra, rb, sg, dv);
      chk($sformatf("rand%0d %h %h s%0d d%0d hi", k, ra, rb, sg, dv), 64'(rh), 64'(ex[63:32]));
      chk($sformatf("rand%0d %h %h s%0d d%0d lo", k, ra, rb, sg, dv), 64'(rl), 64'(ex[31:0]));
      chk($sformatf("rand%0d latency", k), 64'(lat), 64'(W + 1));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
